cpu_ahb2apb_bridge: RTL and testbench
=====================================

CPU_AHB2APB_BRIDGE -- requirements
Module: cpu_ahb2apb_bridge

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, width of haddr and paddr.
REQ-002 SHALL have ports:
- cpu_clk  in  1  sole clock, rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- hsel  in  1  AHB-Lite slave select.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size: 0 byte, 1 half, 2 word.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level HREADY.
- hreadyout  out  1  slave ready.
- hresp  out  2  0 OKAY, 1 ERROR.
- hrdata  out  32  full-word read data, unshifted; upstream lane mux selects bytes.
- psel, penable, pwrite  out  1 each  APB controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB4 byte strobes.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Function
REQ-003 SHALL accept a transfer when hsel & htrans[1] & hready at a rising edge, latching haddr, hwrite and hsize.
REQ-004 SHALL answer hsel with htrans IDLE or BUSY with zero wait states and OKAY, starting no APB access.
REQ-005 SHALL implement FSM states IDLE, WDATA, SETUP, ACCESS, ERR1 and ERR2.
REQ-006 FSM transitions SHALL be:
- IDLE + accepted read -> SETUP.
- IDLE + accepted write -> WDATA.
- WDATA -> SETUP.
- SETUP -> ACCESS.
- ACCESS & !pready -> ACCESS.
- ACCESS & pready & !pslverr -> IDLE.
- ACCESS & pready & pslverr -> ERR1.
- ERR1 -> ERR2.
- ERR2 -> IDLE, or directly to SETUP/WDATA if a transfer is accepted in ERR2.
REQ-007 WDATA SHALL register hwdata into pwdata; pwdata SHALL then be held stable through SETUP and ACCESS.
REQ-008 SETUP SHALL drive psel=1, penable=0; ACCESS SHALL drive psel=1, penable=1.
REQ-009 paddr, pwrite and pstrb SHALL be registered and stable from SETUP through the final ACCESS cycle.
REQ-010 pstrb SHALL decode hsize and haddr[1:0]:
- byte: one-hot lane.
- half: 4'b0011 or 4'b1100.
- word: 4'b1111.
- reads: 4'b0000.
REQ-011 hreadyout SHALL be registered: 0 in WDATA, SETUP, ACCESS and ERR1; 1 in IDLE and ERR2.
REQ-012 Read latency SHALL be: address phase at cycle N -> hreadyout=1 with hrdata=prdata at cycle N+3 when pready=1 on first ACCESS; each pready=0 cycle adds one.
REQ-013 Write latency SHALL be N+4 under the same conditions.
REQ-014 hrdata SHALL be registered on ACCESS & pready & !pwrite and held until the next read completes.
REQ-015 On pslverr, hresp SHALL be 1 in ERR1 and ERR2 (two-cycle AHB error response), and 0 otherwise.
REQ-016 A transfer accepted in the same cycle hreadyout=1 (IDLE or ERR2) SHALL start with no bubble (back-to-back).
REQ-017 Unsupported hsize (>2) SHALL produce an ERROR response via ERR1/ERR2 without asserting psel.
REQ-018 Address inputs SHALL be ignored while hready=0.

Reset
REQ-019 While cpu_rst=1, outputs SHALL immediately be:
- state IDLE, hreadyout=1, hresp=0, hrdata=0.
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
REQ-020 Reset asserted mid-access SHALL abort the APB transfer; no response SHALL be issued for it after release.

Structure
REQ-021 Package cpu_ahb2apb_pkg SHALL hold the FSM state enum, HTRANS and HRESP encodings, and the HSIZE constants.
REQ-022 pstrb decode SHALL be the sub-module cpu_ahb2apb_strb (combinational); the rest is flat.

Verification
REQ-023 Read:
- stimulus: haddr=0x4000_0004, hsize=2, pready=1, prdata=0xA5A5_1234.
- response: psel at N+1, penable at N+2, hreadyout=1 with hrdata=0xA5A5_1234 at N+3.
REQ-024 Byte write:
- stimulus: haddr=0x4000_0003, hsize=0, hwdata=0x7700_0000.
- response: pstrb=4'b1000, pwdata=0x7700_0000, pwrite=1 through SETUP/ACCESS, done at N+4.
REQ-025 Wait states: pready=0 for 3 ACCESS cycles -> penable held 4 cycles, paddr stable, hreadyout rises one cycle after pready.
REQ-026 pslverr=1 on read -> hresp=1 with hreadyout=0, then hresp=1 with hreadyout=1, then IDLE; a NONSEQ issued in ERR2 starts SETUP next cycle.
REQ-027 Back-to-back: read then write issued on the completing cycle -> second transfer enters WDATA with no idle cycle; htrans=BUSY with hsel -> OKAY, psel stays 0.
REQ-028 Reset asserted in ACCESS -> all outputs at reset values that cycle; hsize=3 -> ERROR response, psel never asserted.

Source files
------------

// File: rtl/cpu_ahb2apb_pkg.sv
// cpu_ahb2apb_pkg
//   Shared types and encodings for the AHB-Lite to APB4 bridge:
//   FSM state enum, HTRANS and HRESP encodings, HSIZE constants.
package cpu_ahb2apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'd0,
      HRESP_ERROR = 2'd1
   } hresp_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Only byte, halfword and word transfers map onto a 32-bit APB bus.
   function automatic logic hsize_supported(input logic [2:0] hsize);
      return (hsize <= HSIZE_WORD);
   endfunction

endpackage

// File: rtl/cpu_ahb2apb_strb.sv
// cpu_ahb2apb_strb
//   Combinational APB4 byte-strobe decode from the AHB transfer size and
//   the low address bits. Reads always produce an all-zero strobe.
//   Ports:
//     hwrite  in  1  transfer direction, 1 = write
//     hsize   in  3  AHB transfer size
//     addr_lo in  2  haddr[1:0]
//     pstrb   out 4  byte-lane strobes
module cpu_ahb2apb_strb
   import cpu_ahb2apb_pkg::*;
(
   input  logic       hwrite,
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] pstrb
);

   always_comb begin
      pstrb = '0;
      if (hwrite) begin
         case (hsize)
            HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
            HSIZE_HALF: pstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: pstrb = '1;
            default:    pstrb = '0;
         endcase
      end
   end

endmodule

// File: rtl/cpu_ahb2apb_bridge.sv
// cpu_ahb2apb_bridge
//   AHB-Lite slave to APB4 master bridge, single clock domain.
//   Ports:
//     cpu_clk, cpu_rst                  clock (rising edge), async active-high reset
//     hsel, haddr, htrans, hwrite,
//     hsize, hwdata, hready             AHB-Lite slave inputs
//     hreadyout, hresp, hrdata          AHB-Lite slave response (all registered)
//     psel, penable, pwrite, paddr,
//     pwdata, pstrb                     APB4 master outputs (all registered)
//     prdata, pready, pslverr           APB4 completer response
module cpu_ahb2apb_bridge
   import cpu_ahb2apb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [31:0]       hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic [1:0]        hresp,
   output logic [31:0]       hrdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [31:0]       pwdata,
   output logic [3:0]        pstrb,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   state_t     state;
   state_t     next_state;
   logic       accept;
   logic [3:0] strb_dec;

   cpu_ahb2apb_strb u_strb (
      .hwrite  (hwrite),
      .hsize   (hsize),
      .addr_lo (haddr[1:0]),
      .pstrb   (strb_dec)
   );

   // Address phases are only taken while this slave shows hreadyout=1,
   // i.e. in IDLE or in the second error cycle.
   always_comb begin
      accept = hsel && hready
            && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ))
            && ((state == ST_IDLE) || (state == ST_ERR2));
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_ERR2: begin
            next_state = ST_IDLE;
            if (accept) begin
               if (!hsize_supported(hsize)) next_state = ST_ERR1;
               else if (hwrite)             next_state = ST_WDATA;
               else                         next_state = ST_SETUP;
            end
         end
         ST_WDATA:  next_state = ST_SETUP;
         ST_SETUP:  next_state = ST_ACCESS;
         ST_ACCESS: begin
            if (pready) next_state = pslverr ? ST_ERR1 : ST_IDLE;
         end
         ST_ERR1:   next_state = ST_ERR2;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) state <= ST_IDLE;
      else         state <= next_state;
   end

   // Control outputs are registered from next_state so they line up with
   // the state they describe without any combinational decode on the ports.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         hrdata    <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
      end else begin
         hreadyout <= (next_state == ST_IDLE) || (next_state == ST_ERR2);
         hresp     <= ((next_state == ST_ERR1) || (next_state == ST_ERR2))
                      ? HRESP_ERROR : HRESP_OKAY;
         psel      <= (next_state == ST_SETUP) || (next_state == ST_ACCESS);
         penable   <= (next_state == ST_ACCESS);
         if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            pstrb  <= strb_dec;
         end
         if (state == ST_WDATA) pwdata <= hwdata;
         if ((state == ST_ACCESS) && pready && !pwrite) hrdata <= prdata;
      end
   end

endmodule

// File: tb/tb_cpu_ahb2apb_bridge.sv
// tb_cpu_ahb2apb_bridge
//   Self-checking bench for cpu_ahb2apb_bridge: directed scenarios followed
//   by randomized transfers, checked against latency/strobe rules computed
//   in the bench.
module tb_cpu_ahb2apb_bridge;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [31:0] last_rdata;

   always #5 cpu_clk = ~cpu_clk;

   cpu_ahb2apb_bridge #(.ADDR_W(32)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic set_idle();
      hsel   = 1'b0;
      htrans = 2'd0;
      hwrite = 1'b0;
      hsize  = 3'd0;
      haddr  = $urandom;
   endtask

   // Lanes covered by a naturally aligned transfer of 2**sz bytes.
   function automatic logic [3:0] exp_strb(input logic wr, input logic [2:0] sz, input logic [31:0] a);
      int nb;
      int off;
      if (!wr || sz > 3'd2) return 4'h0;
      nb  = 1 << sz;
      off = (int'(a[1:0]) / nb) * nb;
      return 4'(((1 << nb) - 1) << off);
   endfunction

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_hreadyout"}, 32'(hreadyout), 32'd1);
      chk({pfx, "_hresp"},     32'(hresp),     32'd0);
      chk({pfx, "_hrdata"},    hrdata,         32'd0);
      chk({pfx, "_psel"},      32'(psel),      32'd0);
      chk({pfx, "_penable"},   32'(penable),   32'd0);
      chk({pfx, "_pwrite"},    32'(pwrite),    32'd0);
      chk({pfx, "_paddr"},     paddr,          32'd0);
      chk({pfx, "_pwdata"},    pwdata,         32'd0);
      chk({pfx, "_pstrb"},     32'(pstrb),     32'd0);
   endtask

   task automatic idle_cycle();
      set_idle();
      tick();
      chk("idle_hready", 32'(hreadyout), 32'd1);
      chk("idle_hresp",  32'(hresp),     32'd0);
      chk("idle_psel",   32'(psel),      32'd0);
   endtask

   // One AHB transfer. Returns on the cycle where hreadyout is expected
   // high again (IDLE, or ERR2 on an error), so a following call is issued
   // back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [31:0] data, input int waits, input logic err);
      logic [3:0] es;
      es = exp_strb(wr, sz, addr);
      chk("addr_hready", 32'(hreadyout), 32'd1);
      hsel   = 1'b1;
      htrans = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd3;
      haddr  = addr;
      hwrite = wr;
      hsize  = sz;
      tick();
      set_idle();
      if (wr) begin
         hwdata = data;
         chk("wdata_psel",   32'(psel),      32'd0);
         chk("wdata_hready", 32'(hreadyout), 32'd0);
         tick();
         hwdata = $urandom;
      end
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      chk("setup_psel",    32'(psel),      32'd1);
      chk("setup_penable", 32'(penable),   32'd0);
      chk("setup_hready",  32'(hreadyout), 32'd0);
      chk("setup_paddr",   paddr,          addr);
      chk("setup_pwrite",  32'(pwrite),    32'(wr));
      chk("setup_pstrb",   32'(pstrb),     32'(es));
      if (wr) chk("setup_pwdata", pwdata, data);
      tick();
      for (int i = 0; i <= waits; i++) begin
         pready  = (i == waits);
         pslverr = (i == waits) ? err : 1'($urandom_range(0, 1));
         prdata  = (i == waits) ? data : $urandom;
         chk("acc_psel",    32'(psel),      32'd1);
         chk("acc_penable", 32'(penable),   32'd1);
         chk("acc_hready",  32'(hreadyout), 32'd0);
         chk("acc_hresp",   32'(hresp),     32'd0);
         chk("acc_paddr",   paddr,          addr);
         chk("acc_pwrite",  32'(pwrite),    32'(wr));
         chk("acc_pstrb",   32'(pstrb),     32'(es));
         if (wr) chk("acc_pwdata", pwdata, data);
         tick();
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      if (!wr) last_rdata = data;
      chk("done_psel",    32'(psel),    32'd0);
      chk("done_penable", 32'(penable), 32'd0);
      if (!err) begin
         chk("done_hready", 32'(hreadyout), 32'd1);
         chk("done_hresp",  32'(hresp),     32'd0);
         chk("done_hrdata", hrdata,         last_rdata);
      end else begin
         chk("err1_hresp",  32'(hresp),     32'd1);
         chk("err1_hready", 32'(hreadyout), 32'd0);
         tick();
         chk("err2_hresp",  32'(hresp),     32'd1);
         chk("err2_hready", 32'(hreadyout), 32'd1);
         chk("err2_psel",   32'(psel),      32'd0);
      end
   endtask

   task automatic bad_size(input logic [2:0] sz);
      chk("bad_addr_hready", 32'(hreadyout), 32'd1);
      hsel   = 1'b1;
      htrans = 2'd2;
      haddr  = $urandom;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = sz;
      tick();
      set_idle();
      chk("bad_err1_hresp",  32'(hresp),     32'd1);
      chk("bad_err1_hready", 32'(hreadyout), 32'd0);
      chk("bad_err1_psel",   32'(psel),      32'd0);
      tick();
      chk("bad_err2_hresp",  32'(hresp),     32'd1);
      chk("bad_err2_hready", 32'(hreadyout), 32'd1);
      chk("bad_err2_psel",   32'(psel),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_rst = 1'b1;
      hready  = 1'b1;
      hwdata  = '0;
      prdata  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      set_idle();
      last_rdata = '0;
      #2;
      chk_reset_vals("rst");
      tick();
      tick();
      cpu_rst = 1'b0;
      tick();

      // Reference read, byte write and wait states
      xfer(1'b0, 32'h4000_0004, 3'd2, 32'hA5A5_1234, 0, 1'b0);
      idle_cycle();
      xfer(1'b1, 32'h4000_0003, 3'd0, 32'h7700_0000, 0, 1'b0);
      idle_cycle();
      chk("hrdata_held_after_write", hrdata, 32'hA5A5_1234);
      xfer(1'b0, 32'h4000_1000, 3'd2, $urandom, 3, 1'b0);
      idle_cycle();

      // Error response, then a new transfer issued during ERR2
      xfer(1'b0, 32'h4000_0010, 3'd2, $urandom, 0, 1'b1);
      xfer(1'b0, 32'h4000_0014, 3'd1, $urandom, 1, 1'b0);
      xfer(1'b1, 32'h4000_0022, 3'd1, $urandom, 2, 1'b1);
      idle_cycle();

      // Back-to-back read then write, then BUSY with hsel
      xfer(1'b0, 32'h4000_0100, 3'd2, $urandom, 0, 1'b0);
      xfer(1'b1, 32'h4000_0101, 3'd0, $urandom, 0, 1'b0);
      hsel   = 1'b1;
      htrans = 2'd1;
      hwrite = 1'b1;
      tick();
      chk("busy_hready", 32'(hreadyout), 32'd1);
      chk("busy_hresp",  32'(hresp),     32'd0);
      chk("busy_psel",   32'(psel),      32'd0);
      tick();
      chk("busy_psel2",  32'(psel),      32'd0);

      // Address phase with hready low is ignored
      hsel   = 1'b1;
      htrans = 2'd2;
      hwrite = 1'b1;
      hready = 1'b0;
      tick();
      hready = 1'b1;
      set_idle();
      chk("nordy_psel",   32'(psel),      32'd0);
      chk("nordy_hready", 32'(hreadyout), 32'd1);
      tick();
      chk("nordy_psel2",  32'(psel),      32'd0);

      // Unsupported sizes
      bad_size(3'd3);
      idle_cycle();
      bad_size(3'd7);
      xfer(1'b0, 32'h4000_0200, 3'd2, $urandom, 0, 1'b0);
      idle_cycle();

      // Reset asserted during ACCESS
      hsel   = 1'b1;
      htrans = 2'd2;
      haddr  = 32'h4000_0300;
      hwrite = 1'b0;
      hsize  = 3'd2;
      tick();
      set_idle();
      tick();
      pready = 1'b0;
      chk("rstacc_penable", 32'(penable), 32'd1);
      cpu_rst = 1'b1;
      #1;
      chk_reset_vals("rstacc");
      last_rdata = '0;
      pready = 1'b1;
      prdata = 32'hDEAD_BEEF;
      tick();
      cpu_rst = 1'b0;
      tick();
      pready = 1'b0;
      chk("post_rst_psel",   32'(psel),      32'd0);
      chk("post_rst_hready", 32'(hreadyout), 32'd1);
      chk("post_rst_hresp",  32'(hresp),     32'd0);
      chk("post_rst_hrdata", hrdata,         32'd0);
      idle_cycle();

      // Randomized transfers
      for (int n = 0; n < 30; n++) begin
         xfer(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 2)),
              $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 1) != 0) idle_cycle();
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
